// File: rtl/compr_fetch_aligner.sv
// compr_fetch_aligner: realigns 32-bit fetch words into mixed 16/32-bit instructions and expands RVC
// Ports: i_clk/i_rst_n clock and sync active-low reset; i_flush/i_flush_pc redirect;
//        i_fetch_valid/i_fetch_ready/i_fetch_word/i_fetch_pc fetch side;
//        o_valid/i_ready/o_instr/o_pc/o_is_compr/o_ill_instr decode side.
module compr_fetch_aligner #(
    parameter int XLEN   = 64,
    parameter int BUF_HW = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_flush_pc,
    input  logic            i_fetch_valid,
    output logic            i_fetch_ready,
    input  logic [31:0]     i_fetch_word,
    input  logic [XLEN-1:0] i_fetch_pc,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [31:0]     o_instr,
    output logic [XLEN-1:0] o_pc,
    output logic            o_is_compr,
    output logic            o_ill_instr
);
    localparam int PW = $clog2(BUF_HW);
    localparam int CW = $clog2(BUF_HW + 1);
    localparam bit RV64 = XLEN == 64;

    logic [15:0]     hw_q [BUF_HW];
    logic [XLEN-1:0] pc_q [BUF_HW];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic            skip_lo;
    logic [15:0]     c, next;
    logic            is32, push, pop, ill;
    logic [1:0]      push_n, pop_n;
    logic [31:0]     ex;
    logic [4:0]      rd, rs2, rdp, rs1p;
    logic [11:0]     imm6s;
    logic [20:0]     jimm;
    logic [12:0]     bimm;

    function automatic logic [PW-1:0] wrap(input logic [PW-1:0] p, input int n);
        return PW'((int'(p) + n) % BUF_HW);
    endfunction

    assign c    = hw_q[rd_ptr];
    assign next = hw_q[wrap(rd_ptr, 1)];
    assign is32 = c[1:0] == 2'b11;

    assign o_valid       = i_rst_n && (is32 ? count >= CW'(2) : count != '0);
    assign i_fetch_ready = i_rst_n && count <= CW'(BUF_HW - 2);
    assign push          = i_fetch_valid && i_fetch_ready;
    assign pop           = o_valid && i_ready;
    assign push_n        = !push ? 2'd0 : skip_lo ? 2'd1 : 2'd2;
    assign pop_n         = !pop ? 2'd0 : is32 ? 2'd2 : 2'd1;

    assign o_instr     = !o_valid ? 32'h0 : is32 ? {next, c} : ill ? {16'h0, c} : ex;
    assign o_pc        = o_valid ? pc_q[rd_ptr] : '0;
    assign o_is_compr  = o_valid && !is32;
    assign o_ill_instr = o_valid && !is32 && ill;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            count   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            skip_lo <= i_rst_n && i_flush_pc[1];
        end else begin
            count  <= count + CW'(push_n) - CW'(pop_n);
            rd_ptr <= wrap(rd_ptr, int'(pop_n));
            wr_ptr <= wrap(wr_ptr, int'(push_n));
            if (push && skip_lo) begin
                hw_q[wr_ptr] <= i_fetch_word[31:16];
                pc_q[wr_ptr] <= i_fetch_pc + XLEN'(2);
                skip_lo      <= 1'b0;
            end else if (push) begin
                hw_q[wr_ptr]          <= i_fetch_word[15:0];
                pc_q[wr_ptr]          <= i_fetch_pc;
                hw_q[wrap(wr_ptr, 1)] <= i_fetch_word[31:16];
                pc_q[wrap(wr_ptr, 1)] <= i_fetch_pc + XLEN'(2);
            end
        end
    end

    assign rd    = c[11:7];
    assign rs2   = c[6:2];
    assign rdp   = {2'b01, c[4:2]};
    assign rs1p  = {2'b01, c[9:7]};
    assign imm6s = {{6{c[12]}}, c[12], c[6:2]};
    assign jimm  = {{9{c[12]}}, c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};
    assign bimm  = {{4{c[12]}}, c[12], c[6:5], c[2], c[11:10], c[4:3], 1'b0};

    always_comb begin
        ex  = 32'h0;
        ill = 1'b0;
        case ({c[1:0], c[15:13]})
            5'b00_000: begin
                ex  = {2'b0, c[10:7], c[12:11], c[5], c[6], 2'b0, 5'd2, 3'b000, rdp, 7'h13};
                ill = c[12:5] == 8'h0;
            end
            5'b00_001: ex = {4'b0, c[6:5], c[12:10], 3'b0, rs1p, 3'b011, rdp, 7'h07};
            5'b00_010: ex = {5'b0, c[5], c[12:10], c[6], 2'b0, rs1p, 3'b010, rdp, 7'h03};
            5'b00_011: ex = RV64 ? {4'b0, c[6:5], c[12:10], 3'b0, rs1p, 3'b011, rdp, 7'h03}
                                 : {5'b0, c[5], c[12:10], c[6], 2'b0, rs1p, 3'b010, rdp, 7'h07};
            5'b00_101: ex = {4'b0, c[6:5], c[12], rdp, rs1p, 3'b011, c[11:10], 3'b0, 7'h27};
            5'b00_110: ex = {5'b0, c[5], c[12], rdp, rs1p, 3'b010, c[11:10], c[6], 2'b0, 7'h23};
            5'b00_111: ex = RV64 ? {4'b0, c[6:5], c[12], rdp, rs1p, 3'b011, c[11:10], 3'b0, 7'h23}
                                 : {5'b0, c[5], c[12], rdp, rs1p, 3'b010, c[11:10], c[6], 2'b0, 7'h27};
            5'b01_000: ex = {imm6s, rd, 3'b000, rd, 7'h13};
            5'b01_001: begin
                ex  = RV64 ? {imm6s, rd, 3'b000, rd, 7'h1b}
                           : {jimm[20], jimm[10:1], jimm[11], jimm[19:12], 5'd1, 7'h6f};
                ill = RV64 && rd == 5'd0;
            end
            5'b01_010: ex = {imm6s, 5'd0, 3'b000, rd, 7'h13};
            5'b01_011: begin
                ex  = rd == 5'd2 ? {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0, 5'd2, 3'b000, 5'd2, 7'h13}
                                 : {{14{c[12]}}, c[12], c[6:2], rd, 7'h37};
                ill = {c[12], c[6:2]} == 6'd0;
            end
            5'b01_100: begin
                // 11 selects register-register ops; bit12 picks the RV64 word forms
                ex  = !c[11] ? {1'b0, c[10], 4'b0, c[12], c[6:2], rs1p, 3'b101, rs1p, 7'h13}
                    : !c[10] ? {imm6s, rs1p, 3'b111, rs1p, 7'h13}
                    : {1'b0, c[6:5] == 2'b00, 5'b0, rdp, rs1p,
                       c[12] || c[6:5] == 2'b00 ? 3'b000 : {1'b1, c[6], c[6] & c[5]},
                       rs1p, c[12] ? 7'h3b : 7'h33};
                ill = c[11] ? c[10] && c[12] && (!RV64 || c[6]) : !RV64 && c[12];
            end
            5'b01_101: ex = {jimm[20], jimm[10:1], jimm[11], jimm[19:12], 5'd0, 7'h6f};
            5'b01_110, 5'b01_111:
                ex = {bimm[12], bimm[10:5], 5'd0, rs1p, 2'b00, c[13], bimm[4:1], bimm[11], 7'h63};
            5'b10_000: begin
                ex  = {6'b0, c[12], c[6:2], rd, 3'b001, rd, 7'h13};
                ill = !RV64 && c[12];
            end
            5'b10_001: ex = {3'b0, c[4:2], c[12], c[6:5], 3'b0, 5'd2, 3'b011, rd, 7'h07};
            5'b10_010: begin
                ex  = {4'b0, c[3:2], c[12], c[6:4], 2'b0, 5'd2, 3'b010, rd, 7'h03};
                ill = rd == 5'd0;
            end
            5'b10_011: begin
                ex  = RV64 ? {3'b0, c[4:2], c[12], c[6:5], 3'b0, 5'd2, 3'b011, rd, 7'h03}
                           : {4'b0, c[3:2], c[12], c[6:4], 2'b0, 5'd2, 3'b010, rd, 7'h07};
                ill = RV64 && rd == 5'd0;
            end
            5'b10_100: begin
                ex  = !c[12] ? (rs2 == 5'd0 ? {12'b0, rd, 3'b0, 5'd0, 7'h67} : {7'b0, rs2, 5'd0, 3'b0, rd, 7'h33})
                    : rs2 != 5'd0 ? {7'b0, rs2, rd, 3'b0, rd, 7'h33}
                    : rd == 5'd0 ? 32'h00100073 : {12'b0, rd, 3'b0, 5'd1, 7'h67};
                ill = !c[12] && rs2 == 5'd0 && rd == 5'd0;
            end
            5'b10_101: ex = {3'b0, c[9:7], c[12], rs2, 5'd2, 3'b011, c[11:10], 3'b0, 7'h27};
            5'b10_110: ex = {4'b0, c[8:7], c[12], rs2, 5'd2, 3'b010, c[11:9], 2'b0, 7'h23};
            5'b10_111: ex = RV64 ? {3'b0, c[9:7], c[12], rs2, 5'd2, 3'b011, c[11:10], 3'b0, 7'h23}
                                 : {4'b0, c[8:7], c[12], rs2, 5'd2, 3'b010, c[11:9], 2'b0, 7'h27};
            default:   ill = 1'b1;
        endcase
    end
endmodule
